// File: rtl/test_scanner_if.sv
// Captured-word stream from the test-port scanner to its downstream consumer.
interface test_scanner_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEL_W = 4
);
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [SEL_W-1:0] out_sel;

   modport master (
      output out_valid,
      output out_data,
      output out_sel,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_sel,
      output out_ready
   );
endinterface

// File: rtl/test_scanner.sv
// Sweeps test_sel over [FIRST_SEL, LAST_SEL], samples test_in after a settle
// window and streams each captured word out tagged with its selector code.
module test_scanner #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned SEL_W     = 4,
   parameter int unsigned FIRST_SEL = 0,
   parameter int unsigned LAST_SEL  = 15,
   parameter int unsigned SETTLE    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [SEL_W-1:0] test_sel,
   input  logic [WIDTH-1:0] test_in,
   test_scanner_if.master   out_if,
   output logic             busy,
   output logic             done
);

   // A settle time of zero still needs one edge between selector change and sample.
   localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
   localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_EFF - 1);
   localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(FIRST_SEL);
   localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(LAST_SEL);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_HOLD   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [SEL_W-1:0] sel_q,   sel_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [SEL_W-1:0] osel_q,  osel_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= SEL_FIRST;
         valid_q <= 1'b0;
         data_q  <= '0;
         osel_q  <= SEL_FIRST;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         osel_q  <= osel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: settle countdown, capture, and handshake-driven advance.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      data_d  = data_q;
      osel_d  = osel_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sel_d   = SEL_FIRST;
               cnt_d   = CNT_LOAD;
               state_d = S_SETTLE;
            end
         end

         S_SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               data_d  = test_in;
               osel_d  = sel_q;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (valid_q && out_if.out_ready) begin
               valid_d = 1'b0;
               if (sel_q != SEL_LAST) begin
                  sel_d   = sel_q + SEL_W'(1);
                  cnt_d   = CNT_LOAD;
                  state_d = S_SETTLE;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign test_sel         = sel_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_sel   = osel_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: doc/test_scanner.md
# test_scanner

Sequential reader for a computer's test port: it drives `test_sel` over a configured range of selector codes and samples `test_in` (the computer's `test_out`) after each selector change. Each captured word is delivered downstream on a valid/ready stream, tagged with its selector code. It sits between the `computer` test port and a host-side consumer (UART framer, display driver, or bench checker). It replaces hand-sequenced `test_sel` stimulus with an automatic sweep.

## Interface
- `WIDTH`, 32, width of `test_in` / `out_data`
- `SEL_W`, 4, width of `test_sel` / `out_sel`
- `FIRST_SEL`, 0, first selector code of a sweep
- `LAST_SEL`, 15, last selector code of a sweep; must satisfy `FIRST_SEL <= LAST_SEL`
- `SETTLE`, 2, cycles `test_sel` is held before sampling; 0 is treated as 1

- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `test_sel`  out  SEL_W  selector to the computer's test port
- `test_in`  in  WIDTH  the computer's `test_out`
- `out_valid`  out  1  captured word available
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  WIDTH  captured word
- `out_sel`  out  SEL_W  selector code `out_data` was captured under
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse after the last word of a sweep is accepted

## Operation
- Reset values: state IDLE, `test_sel=FIRST_SEL`, `out_valid=0`, `out_data=0`, `out_sel=FIRST_SEL`, `busy=0`, `done=0`, settle counter 0.
- The FSM has three states: IDLE, SETTLE, HOLD.
- IDLE:
  - `start=1` at an edge: load `test_sel=FIRST_SEL` and counter=`SETTLE`-1, go to SETTLE.
  - `start=0`: stay. `test_sel` keeps its last value.
- SETTLE:
  - While counter != 0: decrement.
  - At the edge where counter == 0: `out_data<=test_in`, `out_sel<=test_sel`, `out_valid<=1`, go to HOLD.
- HOLD:
  - `out_valid=1`. `out_data` and `out_sel` are stable until the transfer.
  - A transfer occurs at an edge with `out_valid && out_ready`.
  - On transfer with `test_sel != LAST_SEL`: `out_valid<=0`, `test_sel<=test_sel+1`, counter=`SETTLE`-1, go to SETTLE.
  - On transfer with `test_sel == LAST_SEL`: `out_valid<=0`, `done<=1` for one cycle, go to IDLE. `test_sel` holds `LAST_SEL`.
- `start` while busy is ignored. There is no queuing.
- `out_ready` may be high before `out_valid` rises. The block must not combinationally depend on `out_ready` for `out_valid`.
- `test_in` is assumed stable through the settle window. It is sampled exactly once per selector code.
- Selector increment is modulo 2^SEL_W. Because `FIRST_SEL <= LAST_SEL`, the sweep never wraps.
- `reset` asserted mid-sweep: immediately return to the reset values. No `done` pulse is produced and no partial word is delivered.

## Timing
- `test_sel` changes on the edge that leaves IDLE or completes a transfer.
- Sample edge: the `SETTLE`-th edge after that change (SETTLE=2 gives the 2nd edge). `out_valid` is high from that edge.
- Minimum cycles per word with `out_ready` tied high: `SETTLE`+1. Each word spends `SETTLE` cycles in SETTLE and 1 cycle in HOLD.
- Full sweep with `out_ready=1`: (`LAST_SEL`-`FIRST_SEL`+1)×(`SETTLE`+1) cycles from the start edge to the `done` edge.
- `done` is high for exactly the cycle following the final transfer edge. `busy` is low in that same cycle.
- The `start` edge latency to first `out_valid` is `SETTLE` edges.

## Test plan
- Defaults, `test_in={28'h0,test_sel}`+32'h100, `out_ready=1`, start pulse:
  - 16 words with `out_sel` 0..15 and `out_data` 32'h100..32'h10F.
  - Each `out_valid` high 1 cycle; 48 cycles start to `done`.
  - `done` high 1 cycle.
- FIRST_SEL=2, LAST_SEL=4, `out_ready` low for 5 cycles on each word:
  - `out_valid`, `out_data` and `out_sel` held stable through each stall.
  - Exactly 3 words are delivered (sel 2, 3, 4), then `done`.
- `test_in` changes from 32'hAAAA_0000 to 32'hBBBB_0000 one cycle after the `test_sel` change (SETTLE=2):
  - The captured value is 32'hBBBB_0000.
  - With SETTLE=1 the captured value is 32'hAAAA_0000.
- `start` pulsed again during a sweep:
  - Ignored; the word count stays 16.
  - A new `start` after `done` begins a fresh sweep at `test_sel=0`.
- `reset` driven low after the 3rd word while in SETTLE:
  - All outputs return to reset values asynchronously.
  - No `done` pulse.
  - After release, a `start` produces a full 16-word sweep.
- SETTLE=0:
  - Behaves identically to SETTLE=1, with 2 cycles per word and `out_ready=1`.
